// File: rtl/des_key_schedule.sv
`default_nettype none
// ============================================================================
// Module      : des_key_schedule (with helper PC1)
// Description : Sequential DES key-schedule generator. Loads a 64-bit key
//               through PC-1, then steps the 28-bit C/D halves to emit the
//               sixteen 48-bit PC-2 round keys, one per valid/ready
//               handshake. Forward order K1..K16 with left rotations for
//               encryption; reverse order K16..K1 with right rotations for
//               decryption.
// Options     : `define DES_KEY_SCHED_PARITY_EN enables the per-octet
//               odd-parity check on the key and drives parity_err. Without
//               it, parity_err is tied low.
// Revision    : 1.0 - initial release
// ============================================================================

// Permuted Choice 1: drops the eight parity bits and reorders the remaining
// 56 bits. Bit numbering is FIPS style; key_i[63] is key bit 1.
module PC1 (
    input  logic [63:0] key_i,
    output logic [55:0] pc1_o
);

    localparam int PC1_TAB [56] = '{
        57, 49, 41, 33, 25, 17,  9,
         1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27,
        19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,
         7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29,
        21, 13,  5, 28, 20, 12,  4
    };

    // pc1_o[55] is PC-1 output bit 1
    for (genvar j = 0; j < 56; j++) begin : g_pc1
        assign pc1_o[55-j] = key_i[64-PC1_TAB[j]];
    end

    // The parity bits (key bits 8, 16, ..., 64) play no part in the permutation.
    logic w_unused_parity_bits;
    assign w_unused_parity_bits = ^{key_i[56], key_i[48], key_i[40], key_i[32],
                                    key_i[24], key_i[16], key_i[8],  key_i[0]};

endmodule

module des_key_schedule (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [63:0] key,
    input  logic        decrypt,
    output logic        busy,
    output logic        subkey_valid,
    input  logic        subkey_ready,
    output logic [47:0] subkey,
    output logic [3:0]  key_idx,
    output logic        last,
    output logic        parity_err
);

    localparam int PC2_TAB [48] = '{
        14, 17, 11, 24,  1,  5,
         3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8,
        16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55,
        30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53,
        46, 42, 50, 36, 29, 32
    };

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [27:0] c_q, c_d;
    logic [27:0] d_q, d_d;
    logic [3:0]  idx_q, idx_d;
    logic        dec_q, dec_d;
    logic        last_q, last_d;

    logic [55:0] w_pc1;
    logic [55:0] w_cd;
    logic        w_hs;
    logic        w_start_acc;
    logic [4:0]  w_round;
    logic        w_two;

    // Rotate a 28-bit half by one or two places; halves never exchange bits.
    function automatic logic [27:0] rot_l(input logic [27:0] x, input logic two);
        return two ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
    endfunction

    function automatic logic [27:0] rot_r(input logic [27:0] x, input logic two);
        return two ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
    endfunction

    PC1 u_pc1 (
        .key_i (key),
        .pc1_o (w_pc1)
    );

    assign busy         = (state_q == S_RUN);
    assign subkey_valid = (state_q == S_RUN);
    assign key_idx      = idx_q;
    assign last         = last_q;
    assign w_hs         = subkey_valid & subkey_ready;
    assign w_start_acc  = (state_q == S_IDLE) & start;

    // Round whose shift amount governs the next step: going forward we move
    // from K(idx+1) to K(idx+2) and apply that round's shift; going backward
    // we undo the shift of the round currently presented, K(idx+1).
    assign w_round = dec_q ? ({1'b0, idx_q} + 5'd1) : ({1'b0, idx_q} + 5'd2);
    assign w_two   = !((w_round == 5'd1) || (w_round == 5'd2) ||
                       (w_round == 5'd9) || (w_round == 5'd16));

    // Round key is a pure function of the C/D registers.
    assign w_cd = {c_q, d_q};
    for (genvar j = 0; j < 48; j++) begin : g_pc2
        assign subkey[47-j] = w_cd[56-PC2_TAB[j]];
    end

    // Next-state logic: load on accepted start, step on handshake, hold otherwise.
    always_comb begin
        state_d = state_q;
        c_d     = c_q;
        d_d     = d_q;
        idx_d   = idx_q;
        dec_d   = dec_q;
        last_d  = last_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                    dec_d   = decrypt;
                    last_d  = 1'b0;
                    if (decrypt) begin
                        // Total rotation over 16 rounds is 28, so C16D16 == C0D0.
                        c_d   = w_pc1[55:28];
                        d_d   = w_pc1[27:0];
                        idx_d = 4'd15;
                    end else begin
                        c_d   = rot_l(w_pc1[55:28], 1'b0);
                        d_d   = rot_l(w_pc1[27:0], 1'b0);
                        idx_d = 4'd0;
                    end
                end
            end
            S_RUN: begin
                if (w_hs) begin
                    if (last_q) begin
                        state_d = S_IDLE;
                        last_d  = 1'b0;
                    end else if (dec_q) begin
                        c_d    = rot_r(c_q, w_two);
                        d_d    = rot_r(d_q, w_two);
                        idx_d  = idx_q - 4'd1;
                        last_d = (idx_q == 4'd1);
                    end else begin
                        c_d    = rot_l(c_q, w_two);
                        d_d    = rot_l(d_q, w_two);
                        idx_d  = idx_q + 4'd1;
                        last_d = (idx_q == 4'd14);
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and schedule registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            c_q     <= '0;
            d_q     <= '0;
            idx_q   <= '0;
            dec_q   <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            c_q     <= c_d;
            d_q     <= d_d;
            idx_q   <= idx_d;
            dec_q   <= dec_d;
            last_q  <= last_d;
        end
    end

`ifdef DES_KEY_SCHED_PARITY_EN
    logic [7:0] w_oct_bad;
    logic       parity_q;
    logic       parity_d;

    // Each key octet must carry odd parity.
    for (genvar g = 0; g < 8; g++) begin : g_parity
        assign w_oct_bad[g] = ~(^key[8*g +: 8]);
    end

    assign parity_d   = w_start_acc ? (|w_oct_bad) : parity_q;
    assign parity_err = parity_q;

    // Parity flag captured with the key load and held until the next start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            parity_q <= 1'b0;
        end else begin
            parity_q <= parity_d;
        end
    end
`else
    logic w_unused_start_acc;
    assign w_unused_start_acc = w_start_acc;
    assign parity_err         = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_des_key_schedule.sv
`default_nettype none
// ============================================================================
// Module      : tb_des_key_schedule
// Description : Self-checking bench for des_key_schedule. Round keys are
//               predicted by a direct FIPS 46 key-schedule model (PC-1,
//               cumulative rotation, PC-2) and compared at every presented
//               subkey. Honours DES_KEY_SCHED_PARITY_EN for parity_err.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_des_key_schedule;

    localparam int PC1_T [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };
    localparam int PC2_T [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };
    localparam int SHIFTS [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    localparam logic [63:0] KEY_STD = 64'h133457799BBCDFF1;
    localparam logic [63:0] KEY_BAD = 64'h123457799BBCDFF1;
    localparam logic [47:0] K1_STD  = 48'h1B02EFFC7072;
    localparam logic [47:0] K16_STD = 48'hCB3D8B0E17F5;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [63:0] key;
    logic        decrypt;
    logic        busy;
    logic        subkey_valid;
    logic        subkey_ready;
    logic [47:0] subkey;
    logic [3:0]  key_idx;
    logic        last;
    logic        parity_err;

    int errors = 0;
    int checks = 0;

    des_key_schedule dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .key          (key),
        .decrypt      (decrypt),
        .busy         (busy),
        .subkey_valid (subkey_valid),
        .subkey_ready (subkey_ready),
        .subkey       (subkey),
        .key_idx      (key_idx),
        .last         (last),
        .parity_err   (parity_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // FIPS bit n (1 = MSB) of a 64-bit word
    function automatic logic kbit(input logic [63:0] v, input int n);
        logic [63:0] t;
        t = v >> (64 - n);
        return t[0];
    endfunction

    // FIPS bit n (1 = MSB) of a 56-bit word
    function automatic logic cdbit(input logic [55:0] v, input int n);
        logic [55:0] t;
        t = v >> (56 - n);
        return t[0];
    endfunction

    // Round key K_round straight from the standard: PC-1, total rotation, PC-2.
    function automatic logic [47:0] ref_key(input logic [63:0] k, input int round);
        logic [27:0] c;
        logic [27:0] d;
        logic [55:0] cd;
        logic [47:0] r;
        int          tot;
        c   = '0;
        d   = '0;
        r   = '0;
        tot = 0;
        for (int i = 0; i < 28; i++) c = {c[26:0], kbit(k, PC1_T[i])};
        for (int i = 28; i < 56; i++) d = {d[26:0], kbit(k, PC1_T[i])};
        for (int i = 0; i < round; i++) tot += SHIFTS[i];
        tot = tot % 28;
        c   = (c << tot) | (c >> (28 - tot));
        d   = (d << tot) | (d >> (28 - tot));
        cd  = {c, d};
        for (int i = 0; i < 48; i++) r = {r[46:0], cdbit(cd, PC2_T[i])};
        return r;
    endfunction

    function automatic logic exp_parity(input logic [63:0] k);
        logic [63:0] t;
        logic        bad;
        bad = 1'b0;
`ifdef DES_KEY_SCHED_PARITY_EN
        for (int i = 0; i < 8; i++) begin
            t = k >> (8 * i);
            if (^t[7:0] == 1'b0) bad = 1'b1;
        end
`else
        t = k;
`endif
        return bad;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"},   64'(busy),         64'd0);
        check({tag, "_valid"},  64'(subkey_valid), 64'd0);
        check({tag, "_last"},   64'(last),         64'd0);
        check({tag, "_idx"},    64'(key_idx),      64'd0);
        check({tag, "_subkey"}, 64'(subkey),       64'd0);
        check({tag, "_parity"}, 64'(parity_err),   64'd0);
    endtask

    // One complete schedule. rpct = subkey_ready duty in percent; poke pulses
    // start with a different key at the sixth key; abort_at >= 0 resets the
    // DUT when that many keys have been consumed.
    task automatic run(input logic [63:0] k, input logic dec, input int rpct,
                       input logic poke, input int abort_at,
                       input logic [47:0] first_exp, input logic [47:0] last_exp);
        logic [47:0] exp_k [16];
        int          n;
        int          cyc;
        int          e;
        logic        hs;
        logic        done;
        logic        aborted;
        for (int r = 1; r <= 16; r++) exp_k[r-1] = ref_key(k, r);

        key          = k;
        decrypt      = dec;
        start        = 1'b1;
        subkey_ready = 1'b0;
        step();
        start   = 1'b0;
        key     = ~k;
        decrypt = ~dec;
        check("start_busy", 64'(busy), 64'd1);
        check("parity_err", 64'(parity_err), 64'(exp_parity(k)));

        n       = 0;
        cyc     = 0;
        done    = 1'b0;
        aborted = 1'b0;
        while (!done && cyc < 400) begin
            start = 1'b0;
            if (abort_at >= 0 && n == abort_at) begin
                rst_n = 1'b0;
                #1;
                check_reset_outputs("midrun_reset");
                #1;
                rst_n   = 1'b1;
                aborted = 1'b1;
                break;
            end
            e = dec ? (15 - n) : n;
            check("valid_in_run", 64'(subkey_valid), 64'd1);
            check("subkey",       64'(subkey),       64'(exp_k[e]));
            check("key_idx",      64'(key_idx),      64'(e));
            check("last",         64'(last),         64'(n == 15));
            if (n == 0 && first_exp != 48'd0) check("first_vector", 64'(subkey), 64'(first_exp));
            if (n == 15 && last_exp != 48'd0) check("last_vector", 64'(subkey), 64'(last_exp));
            if (poke && n == 5) begin
                start   = 1'b1;
                key     = k ^ 64'h0F0F_F0F0_1234_5678;
                decrypt = ~dec;
            end
            subkey_ready = ($urandom_range(0, 99) < rpct);
            hs = subkey_valid && subkey_ready;
            step();
            if (hs) begin
                n++;
                if (n == 16) done = 1'b1;
            end
            cyc++;
        end
        start        = 1'b0;
        subkey_ready = 1'b0;
        if (!aborted) begin
            if (!done) check("schedule_timeout", 64'(n), 64'd16);
            check("end_busy",  64'(busy),         64'd0);
            check("end_valid", 64'(subkey_valid), 64'd0);
        end
        step();
    endtask

    initial begin
        logic [63:0] rk;
        rst_n        = 1'b0;
        start        = 1'b0;
        key          = '0;
        decrypt      = 1'b0;
        subkey_ready = 1'b0;
        step();
        step();
        check_reset_outputs("reset");
        rst_n = 1'b1;
        step();
        check("idle_busy", 64'(busy), 64'd0);

        // Standard vector, forward then reverse.
        run(KEY_STD, 1'b0, 100, 1'b0, -1, K1_STD, K16_STD);
        run(KEY_STD, 1'b1, 100, 1'b0, -1, K16_STD, K1_STD);

        // Back-pressure at 30 percent ready duty.
        run(KEY_STD, 1'b0, 30, 1'b0, -1, K1_STD, K16_STD);

        // Start pulsed with another key while running is ignored.
        run(KEY_STD, 1'b0, 100, 1'b1, -1, K1_STD, K16_STD);

        // Reset at key_idx 8, then restart on the same key.
        run(KEY_STD, 1'b0, 100, 1'b0, 8, K1_STD, K16_STD);
        run(KEY_STD, 1'b0, 100, 1'b0, -1, K1_STD, K16_STD);

        // Key with an even-parity octet still produces its schedule.
        run(KEY_BAD, 1'b0, 100, 1'b0, -1, 48'd0, 48'd0);
        run(KEY_STD, 1'b1, 60, 1'b0, -1, K16_STD, K1_STD);

        // Random keys, directions and ready duty.
        for (int t = 0; t < 6; t++) begin
            rk = {$urandom(), $urandom()};
            run(rk, 1'($urandom_range(0, 1)), int'($urandom_range(20, 100)),
                1'b0, -1, 48'd0, 48'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
